// File: rtl/openhmc_sync_fifo_shift.sv
// Shift-register FIFO: DEPTH register stages, stage 0 is the registered head; optional OPENHMC_SYNC_FIFO_ERR_EN adds sticky overflow/underflow.
// Latency: a write into an empty FIFO reaches d_out after 1 cycle; a pop shows the new head 1 cycle later.
// Backpressure: writes are dropped when full unless paired with a read (shift-through); reads when empty are ignored.
module openhmc_sync_fifo_shift #(
    parameter int DWIDTH     = 8,
    parameter int DEPTH      = 4,
    parameter int AFULL_THR  = 3,
    parameter int AEMPTY_THR = 1,
    parameter int LW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              shift_in,
    input  logic [DWIDTH-1:0] d_in,
    input  logic              shift_out,
    output logic [DWIDTH-1:0] d_out,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [LW-1:0]     level
`ifdef OPENHMC_SYNC_FIFO_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    generate
        if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
            $error("openhmc_sync_fifo_shift: DEPTH must be in 2..64");
        end
        if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
            $error("openhmc_sync_fifo_shift: AFULL_THR must be in 1..DEPTH");
        end
        if (AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
            $error("openhmc_sync_fifo_shift: AEMPTY_THR must be in 0..DEPTH-1");
        end
        if (LW != $clog2(DEPTH + 1)) begin : g_bad_lw
            $error("openhmc_sync_fifo_shift: LW must not be overridden");
        end
    endgenerate

    logic [DWIDTH-1:0] stage_dat [DEPTH];
    logic [DWIDTH-1:0] stage_up  [DEPTH];
    logic [DWIDTH-1:0] stage_nxt [DEPTH];
    logic [DEPTH-1:0]  stage_en;
    logic              wr_ok;
    logic              rd_ok;
    logic [LW-1:0]     lvl_m1;
    logic [LW-1:0]     level_nxt;

    // Valid bits are the thermometer (i < level), so level is the only occupancy state.
    assign empty        = (level == '0);
    assign full         = (level == LW'(DEPTH));
    assign almost_empty = (level <= LW'(AEMPTY_THR));
    assign almost_full  = (level >= LW'(AFULL_THR));
    assign d_out        = stage_dat[0];

    assign wr_ok  = shift_in & (~full | shift_out);
    assign rd_ok  = shift_out & ~empty;
    assign lvl_m1 = level - LW'(1);

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            stage_up[i] = stage_dat[i+1];
        end
        stage_up[DEPTH-1] = '0;
    end

    // Only stages whose contents actually change are enabled.
    always_comb begin
        stage_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stage_nxt[i] = d_in;
            if (rd_ok) begin
                if (wr_ok && LW'(i) == lvl_m1) begin
                    stage_en[i] = 1'b1;
                end else if (LW'(i) < lvl_m1) begin
                    stage_en[i]  = 1'b1;
                    stage_nxt[i] = stage_up[i];
                end
            end else if (wr_ok && LW'(i) == level) begin
                stage_en[i] = 1'b1;
            end
        end
    end

    always_comb begin
        level_nxt = level;
        if (wr_ok && !rd_ok) begin
            level_nxt = level + LW'(1);
        end else if (rd_ok && !wr_ok) begin
            level_nxt = lvl_m1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stage_dat[i] <= '0;
            end
        end else begin
            level <= level_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                if (stage_en[i]) begin
                    stage_dat[i] <= stage_nxt[i];
                end
            end
        end
    end

`ifdef OPENHMC_SYNC_FIFO_ERR_EN
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (shift_in && full && !shift_out) begin
                overflow <= 1'b1;
            end
            if (shift_out && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
